lane_row: RTL

//  Parametrised lane of MAX_OBJ moving objects (cars or logs) for one playfield row; clocked once per frame.

---
 rtl/lane_row.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/lane_row.sv
// lane_row: one playfield row of MAX_OBJ moving objects (cars or logs),
// clocked once per frame. A LOAD phase spreads the objects along the row
// and a RUN phase moves them and wraps them at the screen edges. The row
// also reports the frog hazard and, in log mode, the carry step.
// Optional feature macro: LANE_ROW_RELOAD_EN adds a Reload input that
// restarts LOAD without a full Reset.
module lane_row #(
  parameter int MAX_OBJ  = 4,
  parameter int OBJ_W    = 80,
  parameter int FROG_W   = 40,
  parameter int SCREEN_W = 640,
  parameter int STEP_PX  = 4,
  parameter int MODE     = 0
) (
  input  logic                   frame_clk,
  input  logic                   Reset,
`ifdef LANE_ROW_RELOAD_EN
  input  logic                   Reload,
`endif
  input  logic [3:0]             Number_Objs,
  input  logic [7:0]             Gap_Size,
  input  logic [4:0]             Speed_Div,
  input  logic                   Direction,
  input  logic [10:0]            Row_Y,
  input  logic [10:0]            Frog_X,
  input  logic [10:0]            Frog_Y,
  output logic [MAX_OBJ*11-1:0]  Obj_X,
  output logic [MAX_OBJ-1:0]     Obj_Active,
  output logic                   Hazard,
  output logic [1:0]             Carry_Dx
);

  // Extended space is [0, SPAN): the object's left edge is offset by OBJ_W
  // so an object can slide in from off-screen on either side.
  localparam logic [11:0] SPAN   = 12'(SCREEN_W + OBJ_W);
  localparam logic [11:0] OBJ_W12  = 12'(OBJ_W);
  localparam logic [11:0] FROG_W12 = 12'(FROG_W);
  localparam logic [11:0] STEP12   = 12'(STEP_PX);
  localparam logic [3:0]  LAST_IDX = 4'(MAX_OBJ - 1);
  localparam logic [3:0]  MAX_NUM  = 4'(MAX_OBJ);

  typedef enum logic {S_LOAD = 1'b0, S_RUN = 1'b1} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [10:0]         r_pos [MAX_OBJ];
  logic [11:0]         r_acc;
  logic [3:0]          r_idx;
  logic [4:0]          r_tick;

  logic                w_rst;
  logic                w_run;
  logic [11:0]         w_stride;
  logic                w_fold;
  logic                w_last;
  logic                w_move;
  logic [3:0]          w_num_lim;
  logic                w_frog_row;
  logic [11:0]         w_frog_l;
  logic [11:0]         w_frog_r;
  logic [11:0]         w_pos_ext [MAX_OBJ];
  logic [11:0]         w_pos_nxt [MAX_OBJ];
  logic [MAX_OBJ-1:0]  w_active;
  logic [MAX_OBJ-1:0]  w_overlap;
  logic                w_any;
  logic                w_hazard_nxt;
  logic [1:0]          w_carry_nxt;

`ifdef LANE_ROW_RELOAD_EN
  assign w_rst = Reset | Reload;
`else
  assign w_rst = Reset;
`endif

  assign w_run      = (r_state == S_RUN);
  assign w_stride   = 12'(Gap_Size) + OBJ_W12;
  assign w_fold     = (r_acc >= SPAN);
  assign w_last     = (r_idx == LAST_IDX);
  assign w_move     = w_run && (r_tick >= Speed_Div);
  assign w_num_lim  = (Number_Objs > MAX_NUM) ? MAX_NUM : Number_Objs;
  assign w_frog_row = (Frog_Y == Row_Y);
  assign w_frog_l   = 12'(Frog_X) + OBJ_W12;
  assign w_frog_r   = w_frog_l + FROG_W12;

  for (genvar g = 0; g < MAX_OBJ; g++) begin : g_obj_x
    assign Obj_X[g*11 +: 11] = r_pos[g];
  end

  // State register: Reset (or Reload) always restarts the LOAD phase.
  always_ff @(posedge frame_clk) begin
    if (w_rst) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: leave LOAD once the last slot has been stored.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD: begin
        if (!w_fold && w_last) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_LOAD;
        end
      end
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_LOAD;
    endcase
  end

  // Output logic: slot activity, overlap with the frog, wrapped step positions.
  always_comb begin
    w_any = 1'b0;
    for (int i = 0; i < MAX_OBJ; i++) begin
      w_pos_ext[i] = {1'b0, r_pos[i]};
      w_active[i]  = w_run && (4'(i) < w_num_lim);
      w_overlap[i] = w_frog_row && w_active[i] &&
                     (w_frog_l < w_pos_ext[i] + OBJ_W12) &&
                     (w_pos_ext[i] < w_frog_r);
      w_any = w_any | w_overlap[i];
      if (Direction) begin
        if (w_pos_ext[i] + STEP12 >= SPAN) begin
          w_pos_nxt[i] = w_pos_ext[i] + STEP12 - SPAN;
        end else begin
          w_pos_nxt[i] = w_pos_ext[i] + STEP12;
        end
      end else begin
        if (w_pos_ext[i] < STEP12) begin
          w_pos_nxt[i] = w_pos_ext[i] + SPAN - STEP12;
        end else begin
          w_pos_nxt[i] = w_pos_ext[i] - STEP12;
        end
      end
    end
    if (MODE == 1) begin
      w_hazard_nxt = w_run && w_frog_row && !w_any;
      w_carry_nxt  = (w_move && w_any) ? {1'b1, Direction} : 2'b00;
    end else begin
      w_hazard_nxt = w_any;
      w_carry_nxt  = 2'b00;
    end
  end

  // Datapath: incremental start-position load, frame-divided movement, registered outputs.
  always_ff @(posedge frame_clk) begin
    if (w_rst) begin
      r_acc      <= 12'd0;
      r_idx      <= 4'd0;
      r_tick     <= 5'd0;
      Obj_Active <= '0;
      Hazard     <= 1'b0;
      Carry_Dx   <= 2'b00;
      for (int i = 0; i < MAX_OBJ; i++) begin
        r_pos[i] <= 11'd0;
      end
    end else begin
      Obj_Active <= w_active;
      Hazard     <= w_hazard_nxt;
      Carry_Dx   <= w_carry_nxt;
      case (r_state)
        S_LOAD: begin
          r_tick <= 5'd0;
          if (w_fold) begin
            // one subtraction per frame keeps the adder chain short
            r_acc <= r_acc - SPAN;
          end else begin
            for (int i = 0; i < MAX_OBJ; i++) begin
              if (4'(i) == r_idx) begin
                r_pos[i] <= 11'(r_acc);
              end
            end
            if (!w_last) begin
              r_idx <= r_idx + 4'd1;
            end
            r_acc <= r_acc + w_stride;
          end
        end
        S_RUN: begin
          if (w_move) begin
            r_tick <= 5'd0;
            // inactive slots move too so they stay evenly spaced
            for (int i = 0; i < MAX_OBJ; i++) begin
              r_pos[i] <= 11'(w_pos_nxt[i]);
            end
          end else begin
            r_tick <= r_tick + 5'd1;
          end
        end
        default: begin
          r_tick <= 5'd0;
        end
      endcase
    end
  end

endmodule
